// File: rtl/dac_interp_pkg.sv
// ---------------------------------------------------------------------------
// dac_interp_pkg : shared types and defaults for the DAC interpolator.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dac_interp_pkg;

  localparam int DEF_DATA_WIDTH  = 12;
  localparam int DEF_INTERP_LOG2 = 3;
  localparam int UNDERRUN_CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dac_interp_lerp.sv
// ---------------------------------------------------------------------------
// interp_lerp : prev + floor((cur-prev)*k / R), or prev alone when
// LINEAR_INTERP_EN is undefined (zero-order hold).  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module interp_lerp
  import dac_interp_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INTERP_LOG2 = DEF_INTERP_LOG2
) (
  input  logic signed [DATA_WIDTH-1:0]  prev,
  input  logic signed [DATA_WIDTH-1:0]  cur,
  input  logic        [INTERP_LOG2-1:0] k,
  output logic signed [DATA_WIDTH-1:0]  sample
);

`ifdef LINEAR_INTERP_EN
  localparam int PW = DATA_WIDTH + 1 + INTERP_LOG2;

  logic signed [DATA_WIDTH:0] diff;
  logic signed [PW-1:0]       prod;

  assign diff = {cur[DATA_WIDTH-1], cur} - {prev[DATA_WIDTH-1], prev};
  assign prod = $signed({{INTERP_LOG2{diff[DATA_WIDTH]}}, diff})
              * $signed({{(DATA_WIDTH+1){1'b0}}, k});
  // The step always lies between prev and cur, so truncation is exact.
  assign sample = prev + DATA_WIDTH'(prod >>> INTERP_LOG2);
`else
  logic unused_lerp;

  assign unused_lerp = ^{cur, k};
  assign sample      = prev;
`endif

endmodule

`default_nettype wire

// File: rtl/dac_interp.sv
// ---------------------------------------------------------------------------
// dac_interp : FIFO-fed R-times interpolator for a DAC path; optional
// linear mode via LINEAR_INTERP_EN, zero-order hold otherwise.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dac_interp
  import dac_interp_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INTERP_LOG2 = DEF_INTERP_LOG2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      fifo_empty,
  input  logic [DATA_WIDTH-1:0]     fifo_dout,
  output logic                      fifo_rd_en,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      dout_valid,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

  localparam int R = 1 << INTERP_LOG2;
  localparam logic [INTERP_LOG2-1:0] K_RD   = INTERP_LOG2'(R - 2);
  localparam logic [INTERP_LOG2-1:0] K_LAST = INTERP_LOG2'(R - 1);

  state_t                        state;
  logic [INTERP_LOG2-1:0]        k;
  logic signed [DATA_WIDTH-1:0]  prev;
  logic signed [DATA_WIDTH-1:0]  cur;
  logic signed [DATA_WIDTH-1:0]  pending;
  logic                          pend_valid;
  logic                          rd_q;
  logic signed [DATA_WIDTH-1:0]  sample;
  logic                          fresh_valid;
  logic signed [DATA_WIDTH-1:0]  fresh;

  assign fifo_rd_en = !rst && ena && !fifo_empty &&
                      ((state == S_IDLE) || ((state == S_RUN) && (k == K_RD)));

  // A word returning in the same cycle as the interval swap is forwarded.
  assign fresh_valid = pend_valid | rd_q;
  assign fresh       = rd_q ? $signed(fifo_dout) : pending;

  interp_lerp #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INTERP_LOG2 (INTERP_LOG2)
  ) u_lerp (
    .prev   (prev),
    .cur    (cur),
    .k      (k),
    .sample (sample)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      k            <= '0;
      prev         <= '0;
      cur          <= '0;
      pending      <= '0;
      pend_valid   <= 1'b0;
      rd_q         <= 1'b0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      dout_valid <= 1'b0;
      underrun   <= 1'b0;
      rd_q       <= fifo_rd_en && (state == S_RUN);
      if (rd_q) begin
        pending    <= fifo_dout;
        pend_valid <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (fifo_rd_en) state <= S_PRIME;
        end
        // The primed word is on the bus now whatever ena does.
        S_PRIME: begin
          prev  <= fifo_dout;
          cur   <= fifo_dout;
          k     <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (ena) begin
            dout       <= sample;
            dout_valid <= 1'b1;
            k          <= k + 1'b1;
            if (k == K_LAST) begin
              prev       <= cur;
              pend_valid <= 1'b0;
              if (fresh_valid) begin
                cur <= fresh;
              end else begin
                underrun <= 1'b1;
                if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dac_interp.sv
// ---------------------------------------------------------------------------
// tb_dac_interp : table-driven scoreboard bench for dac_interp at R=4.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dac_interp;

  localparam int W     = 12;
  localparam int L     = 2;
  localparam int NCASE = 4;
`ifdef LINEAR_INTERP_EN
  localparam bit LIN = 1'b1;
`else
  localparam bit LIN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          fifo_empty;
  logic [W-1:0]  fifo_dout;
  logic          fifo_rd_en;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          underrun;
  logic [15:0]   underrun_cnt;

  always #5 clk = ~clk;

  dac_interp #(.DATA_WIDTH(W), .INTERP_LOG2(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_rd_en   (fifo_rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  typedef struct packed {
    int n_samp;
    int cycles;
    bit toggle;
    int n_exp;
    int underruns;
    int reads;
  } vec_t;

  vec_t vec [NCASE];
  int samp [NCASE][3] = '{'{0, 400, -400}, '{0, 3, 0}, '{0, 400, 0}, '{0, 400, -400}};
  int exp_lin [NCASE][12] = '{
    '{0, 0, 0, 0, 0, 100, 200, 300, 400, 200, 0, -200},
    '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 100, 200, 300, 400, 400, 400, 400},
    '{0, 0, 0, 0, 0, 100, 200, 300, 400, 200, 0, -200}};
  int exp_zoh [NCASE][12] = '{
    '{0, 0, 0, 0, 0, 0, 0, 0, 400, 400, 400, 400},
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0, 400, 400, 400, 400},
    '{0, 0, 0, 0, 0, 0, 0, 0, 400, 400, 400, 400}};

  int fifo_q [$];
  int exp_q  [$];
  int checks   = 0;
  int failures = 0;
  int reads;
  int pulses;

  task automatic fail(input string name, input int act, input int req);
    checks++;
    failures++;
    $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  task automatic check(input string name, input int act, input int req);
    if (act !== req) fail(name, act, req);
    else checks++;
  endtask

  task automatic observe();
    if (dout_valid) begin
      if (exp_q.size() == 0) fail("extra_output", $signed(dout), 0);
      else check("dout", $signed(dout), exp_q.pop_front());
    end
    if (underrun) begin
      pulses++;
      check("underrun_cnt", int'(underrun_cnt), pulses);
    end
  endtask

  // One clk cycle: drive, evaluate the read strobe, step the edge, sample.
  task automatic cycle(input logic e, input logic r);
    logic rd_now;
    int   v;
    ena        = e;
    rst        = r;
    fifo_empty = (fifo_q.size() == 0);
    #1;
    rd_now = fifo_rd_en;
    if (r) check("rd_en_in_rst", int'(fifo_rd_en), 0);
    if (rd_now && fifo_empty) fail("rd_en_while_empty", 1, 0);
    if (rd_now) reads++;
    @(posedge clk);
    #1;
    if (rd_now && fifo_q.size() > 0) begin
      v         = fifo_q.pop_front();
      fifo_dout = v[W-1:0];
    end
    if (!r) observe();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"}, int'(dout), 0);
    check({tag, "_dout_valid"}, int'(dout_valid), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
    check({tag, "_underrun_cnt"}, int'(underrun_cnt), 0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    check_zero("reset");
    reads  = 0;
    pulses = 0;
  endtask

  task automatic run_case(input int c);
    logic e;
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < vec[c].n_samp; i++) fifo_q.push_back(samp[c][i]);
    do_reset();
    for (int i = 0; i < vec[c].n_exp; i++)
      exp_q.push_back(LIN ? exp_lin[c][i] : exp_zoh[c][i]);
    for (int i = 0; i < vec[c].cycles; i++) begin
      e = vec[c].toggle ? ((i % 2) == 0) : 1'b1;
      cycle(e, 1'b0);
      if (vec[c].toggle && i >= 2) check("valid_mirrors_ena", int'(dout_valid), int'(e));
    end
    check("outputs_missing", exp_q.size(), 0);
    check("fifo_reads", reads, vec[c].reads);
    check("underrun_pulses", pulses, vec[c].underruns);
    check("underrun_cnt_final", int'(underrun_cnt), vec[c].underruns);
  endtask

  initial begin
    int read_cyc;
    int first_cyc;
    int reads_before;

    vec[0] = '{n_samp: 3, cycles: 14, toggle: 1'b0, n_exp: 12, underruns: 1, reads: 3};
    vec[1] = '{n_samp: 2, cycles: 10, toggle: 1'b0, n_exp: 8,  underruns: 1, reads: 2};
    vec[2] = '{n_samp: 2, cycles: 14, toggle: 1'b0, n_exp: 12, underruns: 2, reads: 2};
    vec[3] = '{n_samp: 3, cycles: 25, toggle: 1'b1, n_exp: 12, underruns: 1, reads: 3};

    rst        = 1'b1;
    ena        = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    @(posedge clk);
    #1;

    for (int c = 0; c < NCASE; c++) run_case(c);

    // Reset mid-stream at k=2 of the second interval, then restart.
    fifo_q.delete();
    exp_q.delete();
    fifo_q.push_back(0);
    fifo_q.push_back(400);
    fifo_q.push_back(-400);
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(0);
    exp_q.push_back(LIN ? 100 : 0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    check_zero("midrst");
    check("midrst_outputs_missing", exp_q.size(), 0);
    pulses = 0;

    for (int i = 0; i < 6; i++) exp_q.push_back(-400);
    read_cyc  = -1;
    first_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      reads_before = reads;
      cycle(1'b1, 1'b0);
      if (reads != reads_before && read_cyc < 0) read_cyc = i;
      if (dout_valid && first_cyc < 0) first_cyc = i;
    end
    check("restart_read_cycle", read_cyc, 0);
    check("restart_latency", first_cyc + 1 - read_cyc, 3);
    check("restart_outputs_missing", exp_q.size(), 0);
    check("restart_underruns", pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dac_interp.md
DAC_INTERP -- requirements
Module: dac_interp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: sample width, signed two's complement.
REQ-002 SHALL have parameter INTERP_LOG2, default 3: log2 of interpolation ratio R; legal range 1..6.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port ena, input, 1: output-rate enable; one output sample per clk cycle with ena high.
REQ-006 SHALL have port fifo_empty, input, 1: source FIFO empty flag.
REQ-007 SHALL have port fifo_dout, input, DATA_WIDTH: FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 SHALL have port fifo_rd_en, output, 1: FIFO read strobe; combinational from registered state, phase, ena and fifo_empty only.
REQ-009 SHALL have port dout, output, DATA_WIDTH: interpolated sample to DAC path, registered.
REQ-010 SHALL have port dout_valid, output, 1: dout qualifier, registered.
REQ-011 SHALL have port underrun, output, 1: one-cycle pulse when an interval starts without fresh data.
REQ-012 SHALL have port underrun_cnt, output, 16: saturating underrun count.

Function
REQ-013 SHALL implement states S_IDLE, S_PRIME, S_RUN.
REQ-014 S_IDLE: with ena high and fifo_empty low, fifo_rd_en SHALL assert for one cycle; next state S_PRIME.
REQ-015 S_PRIME: fifo_dout SHALL load both prev and cur; phase k=0; next state S_RUN.
REQ-016 S_RUN: each ena-high cycle SHALL register dout = prev + (((cur-prev)*k) >>> INTERP_LOG2), with dout_valid=1, then k=k+1 mod R.
REQ-017 Difference SHALL be computed in DATA_WIDTH+1 bits; the product in DATA_WIDTH+1+INTERP_LOG2 bits; the shift is arithmetic (floor); the result needs no saturation.
REQ-018 At k==R-2 with ena high and fifo_empty low, fifo_rd_en SHALL assert; the returned word SHALL be captured next cycle into a pending register with a pending-valid flag, regardless of ena.
REQ-019 At k==R-1 with ena high: prev<=cur; cur<=pending if pending-valid, else cur<=cur with underrun=1 and underrun_cnt+1 (saturating at 65535); pending-valid SHALL clear.
REQ-020 ena low SHALL freeze state, k, prev and cur; dout_valid=0; dout holds its value; fifo_rd_en=0.
REQ-021 First dout_valid SHALL occur 3 cycles after the S_IDLE cycle that asserts fifo_rd_en, with ena held high.
REQ-022 Exactly one FIFO read SHALL occur per R output samples in steady state; fifo_rd_en SHALL never assert while fifo_empty is high.

Reset
REQ-023 rst SHALL force S_IDLE, k=0, prev=cur=pending=0, pending-valid=0, dout=0, dout_valid=0, underrun=0, underrun_cnt=0.
REQ-024 rst SHALL take priority over all events; fifo_rd_en SHALL be 0 in every cycle with rst high; a read issued in the cycle before rst SHALL be discarded.

Configuration
REQ-025 With LINEAR_INTERP_EN defined, SHALL interpolate per REQ-016.
REQ-026 Without LINEAR_INTERP_EN, SHALL zero-order hold (dout=prev for all k); the multiplier SHALL be removed; timing, handshake and underrun behaviour SHALL be unchanged.

Structure
REQ-027 Package dac_interp_pkg SHALL hold the state enum, the DATA_WIDTH and INTERP_LOG2 defaults, and the underrun counter width.
REQ-028 Arithmetic of REQ-016/017 SHALL live in sub-module interp_lerp (combinational: prev, cur, k in; sample out).

Verification (R=4, LINEAR_INTERP_EN defined unless noted)
REQ-029 FIFO holds 0,400,-400; ena=1 -> dout sequence 0,0,0,0, 0,100,200,300, 400,200,0,-200.
REQ-030 Floor rounding: samples 0,3 -> second interval 0,0,1,2.
REQ-031 FIFO empties after 0,400 -> third interval repeats 400 x4, underrun pulses once per interval, underrun_cnt increments 1,2,...; no fifo_rd_en while empty.
REQ-032 ena toggled 1010... -> dout_valid mirrors ena delayed one cycle; sample values identical to REQ-029; FIFO reads=1 per 4 valid outputs.
REQ-033 rst asserted at k=2 of the second interval -> all outputs 0 next cycle; after release, restart from S_IDLE with first output 3 cycles after read.
REQ-034 LINEAR_INTERP_EN undefined, samples 0,400 -> 0,0,0,0, 0,0,0,0, 400...
